// File: rtl/krz_mem_arbiter_if.sv
// Bus bundle between the Kronos core ports, the arbiter and the memory macro.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface krz_mem_arbiter_if #(
    parameter int AW = 10
);
    logic [31:0]   instr_addr;
    logic          instr_req;
    logic          instr_ack;
    logic [31:0]   instr_data;

    logic [31:0]   data_addr;
    logic [31:0]   data_wr_data;
    logic [3:0]    data_mask;
    logic          data_wr_en;
    logic          data_req;
    logic          data_ack;
    logic [31:0]   data_rd_data;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_mask;
    logic [31:0]   mem_rdata;

    modport slave (
        input  instr_addr, instr_req,
        input  data_addr, data_wr_data, data_mask, data_wr_en, data_req,
        input  mem_rdata,
        output instr_ack, instr_data,
        output data_ack, data_rd_data,
        output mem_en, mem_wr, mem_addr, mem_wdata, mem_mask
    );

    modport master (
        output instr_addr, instr_req,
        output data_addr, data_wr_data, data_mask, data_wr_en, data_req,
        output mem_rdata,
        input  instr_ack, instr_data,
        input  data_ack, data_rd_data,
        input  mem_en, mem_wr, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/krz_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported, 1-cycle-latency memory between
// the instruction-fetch and data ports; out-of-range accesses complete without memory.
module krz_mem_arbiter #(
    parameter int AW = 10
) (
    input logic              clk,
    input logic              rst,
    krz_mem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY}  state_t;
    typedef enum logic {INSTR, DATA} port_t;

    state_t state_reg;
    port_t  owner_reg;
    port_t  last_reg;
    logic   oor_reg;

    logic        instr_cand;
    logic        data_cand;
    logic        grant;
    logic        win_data;
    logic        sel_oor;
    logic        mem_en_int;
    logic [31:0] sel_addr;
    logic        unused_addr_bits;

    // The owner's req is still high during its ack cycle, so it must sit out that cycle.
    assign instr_cand = bus.instr_req && (state_reg == IDLE || owner_reg == DATA);
    assign data_cand  = bus.data_req  && (state_reg == IDLE || owner_reg == INSTR);
    assign grant      = instr_cand || data_cand;
    assign win_data   = data_cand && (!instr_cand || last_reg == INSTR);

    assign sel_addr         = win_data ? bus.data_addr : bus.instr_addr;
    assign sel_oor          = |sel_addr[31:AW+2];
    assign unused_addr_bits = ^sel_addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            owner_reg <= INSTR;
            last_reg  <= INSTR;
            oor_reg   <= 1'b0;
        end else if (grant) begin
            state_reg <= BUSY;
            owner_reg <= win_data ? DATA : INSTR;
            last_reg  <= win_data ? DATA : INSTR;
            oor_reg   <= sel_oor;
        end else begin
            state_reg <= IDLE;
        end
    end

    // Out-of-range grants still complete, but never strobe the memory.
    assign mem_en_int    = grant && !sel_oor && !rst;
    assign bus.mem_en    = mem_en_int;
    assign bus.mem_wr    = mem_en_int && win_data && bus.data_wr_en;
    assign bus.mem_addr  = sel_addr[AW+1:2];
    assign bus.mem_wdata = bus.data_wr_data;
    assign bus.mem_mask  = win_data ? bus.data_mask : 4'hF;

    assign bus.instr_ack    = (state_reg == BUSY) && (owner_reg == INSTR);
    assign bus.data_ack     = (state_reg == BUSY) && (owner_reg == DATA);
    assign bus.instr_data   = (bus.instr_ack && oor_reg) ? 32'h0 : bus.mem_rdata;
    assign bus.data_rd_data = (bus.data_ack  && oor_reg) ? 32'h0 : bus.mem_rdata;
endmodule

// File: tb/tb_krz_mem_arbiter.sv
// Directed bench for krz_mem_arbiter with a byte-masked 1-cycle-latency memory model.
module tb_krz_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    krz_mem_arbiter_if #(.AW(10)) bus ();
    krz_mem_arbiter #(.AW(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [0:1023];
    int checks = 0;
    int failures = 0;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_wr && bus.mem_mask[b])
                    mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.instr_req = 1'b1; bus.instr_addr = 32'h10;
        bus.data_req = 1'b1; bus.data_addr = 32'h8; bus.data_wr_en = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        if (bus.instr_ack !== 1'b0) begin failures++; $display("FAIL reset_instr_ack got=%b exp=0", bus.instr_ack); end checks++;
        if (bus.data_ack !== 1'b0) begin failures++; $display("FAIL reset_data_ack got=%b exp=0", bus.data_ack); end checks++;
        if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", bus.mem_en); end checks++;
        if (bus.mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", bus.mem_wr); end checks++;
        cyc();
        bus.instr_req = 1'b0; bus.data_req = 1'b0; bus.data_wr_en = 1'b0;
        rst = 1'b0;
        cyc();
        $display("txn reset done");
    endtask

    task automatic test_lone_fetch();
        bus.instr_req = 1'b1; bus.instr_addr = 32'h10;
        @(negedge clk);
        if (bus.mem_en !== 1'b1) begin failures++; $display("FAIL fetch_mem_en got=%b exp=1", bus.mem_en); end checks++;
        if (bus.mem_addr !== 10'd4) begin failures++; $display("FAIL fetch_mem_addr got=%0d exp=4", bus.mem_addr); end checks++;
        if (bus.mem_wr !== 1'b0 || bus.mem_mask !== 4'hF) begin failures++; $display("FAIL fetch_wr_mask got=%b/%h exp=0/f", bus.mem_wr, bus.mem_mask); end checks++;
        if (bus.instr_ack !== 1'b0) begin failures++; $display("FAIL fetch_early_ack got=%b exp=0", bus.instr_ack); end checks++;
        cyc();
        @(negedge clk);
        if (bus.instr_ack !== 1'b1) begin failures++; $display("FAIL fetch_ack got=%b exp=1", bus.instr_ack); end checks++;
        if (bus.instr_data !== 32'h00000013) begin failures++; $display("FAIL fetch_data got=%h exp=00000013", bus.instr_data); end checks++;
        if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL fetch_owner_regrant got=%b exp=0", bus.mem_en); end checks++;
        $display("txn fetch addr=00000010 data=%h", bus.instr_data);
        cyc();
        bus.instr_req = 1'b0;
        @(negedge clk);
        if (bus.instr_ack !== 1'b0) begin failures++; $display("FAIL fetch_ack_pulse got=%b exp=0", bus.instr_ack); end checks++;
        cyc();
    endtask

    task automatic test_first_contention();
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        bus.instr_req = 1'b1; bus.instr_addr = 32'h10;
        bus.data_req = 1'b1; bus.data_addr = 32'h8; bus.data_wr_en = 1'b0;
        @(negedge clk);
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd2) begin failures++; $display("FAIL contend_first_grant got=en%b/addr%0d exp=en1/addr2", bus.mem_en, bus.mem_addr); end checks++;
        cyc();
        bus.data_req = 1'b0;
        @(negedge clk);
        if (bus.data_ack !== 1'b1 || bus.data_rd_data !== 32'hA5A50002) begin failures++; $display("FAIL contend_data_ack got=%b/%h exp=1/a5a50002", bus.data_ack, bus.data_rd_data); end checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd4) begin failures++; $display("FAIL contend_instr_grant got=en%b/addr%0d exp=en1/addr4", bus.mem_en, bus.mem_addr); end checks++;
        $display("txn data load addr=00000008 data=%h", bus.data_rd_data);
        cyc();
        bus.instr_req = 1'b0;
        @(negedge clk);
        if (bus.instr_ack !== 1'b1 || bus.instr_data !== 32'h13 || bus.data_ack !== 1'b0) begin failures++; $display("FAIL contend_instr_ack got=%b/%h/d%b exp=1/00000013/d0", bus.instr_ack, bus.instr_data, bus.data_ack); end checks++;
        $display("txn fetch addr=00000010 data=%h", bus.instr_data);
        cyc();
    endtask

    task automatic test_sustained();
        int dacks = 0;
        int iacks = 0;
        bus.instr_req = 1'b1; bus.instr_addr = 32'h10;
        bus.data_req = 1'b1; bus.data_addr = 32'h8; bus.data_wr_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.mem_en !== 1'b1) begin failures++; $display("FAIL sustain_mem_en k=%0d got=%b exp=1", k, bus.mem_en); end checks++;
            if (bus.mem_addr !== ((k % 2 == 0) ? 10'd2 : 10'd4)) begin failures++; $display("FAIL sustain_grant k=%0d got=%0d exp=%0d", k, bus.mem_addr, (k % 2 == 0) ? 2 : 4); end checks++;
            if (k > 0) begin
                if (bus.data_ack !== (k % 2 == 1) || bus.instr_ack !== (k % 2 == 0)) begin failures++; $display("FAIL sustain_ack k=%0d got=d%b/i%b", k, bus.data_ack, bus.instr_ack); end checks++;
            end
            if (bus.data_ack === 1'b1) begin
                dacks++;
                if (bus.data_rd_data !== 32'hA5A50002) begin failures++; $display("FAIL sustain_data k=%0d got=%h exp=a5a50002", k, bus.data_rd_data); end checks++;
            end
            if (bus.instr_ack === 1'b1) iacks++;
            if (k < 19) cyc();
        end
        cyc();
        bus.instr_req = 1'b0; bus.data_req = 1'b0;
        @(negedge clk);
        if (bus.instr_ack === 1'b1) iacks++;
        if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL sustain_drain_en got=%b exp=0", bus.mem_en); end checks++;
        if (dacks !== 10 || iacks !== 10) begin failures++; $display("FAIL sustain_ack_count got=d%0d/i%0d exp=d10/i10", dacks, iacks); end checks++;
        $display("txn sustained contention data_acks=%0d instr_acks=%0d", dacks, iacks);
        cyc();
    endtask

    task automatic test_store_load();
        bus.data_req = 1'b1; bus.data_addr = 32'h20; bus.data_wr_en = 1'b1;
        bus.data_wr_data = 32'hDEADBEEF; bus.data_mask = 4'b0011;
        @(negedge clk);
        if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_addr !== 10'd8) begin failures++; $display("FAIL store_grant got=en%b/wr%b/addr%0d exp=en1/wr1/addr8", bus.mem_en, bus.mem_wr, bus.mem_addr); end checks++;
        if (bus.mem_mask !== 4'b0011 || bus.mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL store_drive got=%h/%h exp=3/deadbeef", bus.mem_mask, bus.mem_wdata); end checks++;
        cyc();
        bus.data_req = 1'b0; bus.data_wr_en = 1'b0;
        @(negedge clk);
        if (bus.data_ack !== 1'b1 || bus.mem_wr !== 1'b0) begin failures++; $display("FAIL store_ack got=ack%b/wr%b exp=ack1/wr0", bus.data_ack, bus.mem_wr); end checks++;
        $display("txn store addr=00000020 data=deadbeef mask=3");
        cyc();
        bus.data_req = 1'b1;
        @(negedge clk);
        if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b0) begin failures++; $display("FAIL load_grant got=en%b/wr%b exp=en1/wr0", bus.mem_en, bus.mem_wr); end checks++;
        cyc();
        bus.data_req = 1'b0;
        @(negedge clk);
        if (bus.data_ack !== 1'b1 || bus.data_rd_data !== 32'h0000BEEF) begin failures++; $display("FAIL load_data got=%b/%h exp=1/0000beef", bus.data_ack, bus.data_rd_data); end checks++;
        $display("txn load addr=00000020 data=%h", bus.data_rd_data);
        cyc();
    endtask

    task automatic test_out_of_range();
        bus.data_req = 1'b1; bus.data_addr = 32'h1000; bus.data_wr_en = 1'b0;
        @(negedge clk);
        if (bus.mem_en !== 1'b0 || bus.data_ack !== 1'b0) begin failures++; $display("FAIL oor_load_grant got=en%b/ack%b exp=en0/ack0", bus.mem_en, bus.data_ack); end checks++;
        cyc();
        bus.data_req = 1'b0;
        @(negedge clk);
        if (bus.data_ack !== 1'b1 || bus.data_rd_data !== 32'h0) begin failures++; $display("FAIL oor_load_ack got=%b/%h exp=1/00000000", bus.data_ack, bus.data_rd_data); end checks++;
        $display("txn oor load addr=00001000 data=%h", bus.data_rd_data);
        cyc();
        bus.data_req = 1'b1; bus.data_wr_en = 1'b1; bus.data_wr_data = 32'hFFFFFFFF; bus.data_mask = 4'hF;
        @(negedge clk);
        if (bus.mem_en !== 1'b0 || bus.mem_wr !== 1'b0) begin failures++; $display("FAIL oor_store_grant got=en%b/wr%b exp=en0/wr0", bus.mem_en, bus.mem_wr); end checks++;
        cyc();
        bus.data_req = 1'b0; bus.data_wr_en = 1'b0;
        @(negedge clk);
        if (bus.data_ack !== 1'b1) begin failures++; $display("FAIL oor_store_ack got=%b exp=1", bus.data_ack); end checks++;
        if (mem[0] !== 32'h12345678) begin failures++; $display("FAIL oor_mem_intact got=%h exp=12345678", mem[0]); end checks++;
        $display("txn oor store addr=00001000 dropped");
        cyc();
    endtask

    task automatic test_reset_busy();
        bus.instr_req = 1'b1; bus.instr_addr = 32'h10;
        @(negedge clk);
        if (bus.mem_en !== 1'b1) begin failures++; $display("FAIL rbusy_grant got=%b exp=1", bus.mem_en); end checks++;
        cyc();
        rst = 1'b1;
        #1;
        if (bus.instr_ack !== 1'b0 || bus.mem_en !== 1'b0) begin failures++; $display("FAIL rbusy_ack_lost got=ack%b/en%b exp=ack0/en0", bus.instr_ack, bus.mem_en); end checks++;
        cyc();
        @(negedge clk);
        if (bus.instr_ack !== 1'b0 || bus.mem_en !== 1'b0) begin failures++; $display("FAIL rbusy_held got=ack%b/en%b exp=ack0/en0", bus.instr_ack, bus.mem_en); end checks++;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd4) begin failures++; $display("FAIL rbusy_regrant got=en%b/addr%0d exp=en1/addr4", bus.mem_en, bus.mem_addr); end checks++;
        cyc();
        bus.instr_req = 1'b0;
        @(negedge clk);
        if (bus.instr_ack !== 1'b1 || bus.instr_data !== 32'h13) begin failures++; $display("FAIL rbusy_fetch got=%b/%h exp=1/00000013", bus.instr_ack, bus.instr_data); end checks++;
        $display("txn fetch after reset data=%h", bus.instr_data);
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h12345678;
        mem[2] = 32'hA5A50002;
        mem[4] = 32'h00000013;
        bus.instr_addr = 32'h0; bus.instr_req = 1'b0;
        bus.data_addr = 32'h0; bus.data_wr_data = 32'h0; bus.data_mask = 4'h0;
        bus.data_wr_en = 1'b0; bus.data_req = 1'b0;
        rst = 1'b1;
        test_reset();
        test_lone_fetch();
        test_first_contention();
        test_sustained();
        test_store_load();
        test_out_of_range();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
